data_mem_bus_interface: RTL and testbench

Load/store bus interface in the MEM stage. Takes the pipeline's memory request (address, op code, and store data already narrowed by the data-memory handler) and drives a word-addressed external data bus with a req/ready handshake and byte strobes. It stalls the pipeline until the transfer completes. On loads it returns the bus word right-shifted so the addressed byte or halfword lands at bit 0, ready for the handler's sign/zero extension.

---
 rtl/data_mem_bus_interface.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_bus_interface.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus_interface.sv
// MEM-stage load/store bridge onto a word-addressed req/ready data bus with byte strobes.
// Optional REQ abort after TIMEOUT_CYCLES without bus_ready: define DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | evaluate MemRead/MemWrite; misaligned accesses are rejected here
// REQ   | bus_req held with latched command until bus_ready (or timeout)
// DONE  | pipeline released, rdata/bus_err valid for this one cycle
module data_mem_bus_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DataMemOutOp,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_word_addr;
  logic [1:0]  r_lane;
  logic        r_we;
  logic        r_narrow;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_access;
  logic        w_misalign;
  logic        w_start;
  logic        w_in_req;
  logic        w_complete;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_shifted;
  logic [31:0] w_rd_aligned;

  assign w_is_byte  = (DataMemOutOp == OP_LB) || (DataMemOutOp == OP_LBU);
  assign w_is_half  = (DataMemOutOp == OP_LH) || (DataMemOutOp == OP_LHU);
  assign w_is_word  = !w_is_byte && !w_is_half;
  assign w_misalign = (w_is_word && (addr[1:0] != 2'b00)) || (w_is_half && addr[0]);
  assign w_access   = MemRead | MemWrite;
  assign w_start    = (r_state == ST_IDLE) && w_access && !w_misalign;
  assign w_in_req   = (r_state == ST_REQ);
  assign w_complete = w_in_req && bus_ready;

  // Loads present no strobes and zero write data on the bus.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = 32'd0;
    if (MemWrite) begin
      if (w_is_byte) begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{write_data[7:0]}};
      end else if (w_is_half) begin
        w_wstrb = 4'b0011 << addr[1:0];
        w_wdata = {2{write_data[15:0]}};
      end else begin
        w_wstrb = 4'b1111;
        w_wdata = write_data;
      end
    end
  end

  assign w_rd_shifted = bus_rdata >> {r_lane, 3'b000};
  assign w_rd_aligned = r_we ? 32'd0 : (r_narrow ? w_rd_shifted : bus_rdata);

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       r_bus_err;

  // Counts REQ cycles already spent; the last allowed cycle may still complete.
  assign w_timeout = w_in_req && !bus_ready && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= 8'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_start) begin
        r_to_cnt <= 8'd0;
      end else if (w_in_req) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_REQ;
      ST_REQ:  if (w_complete || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_addr <= 30'd0;
      r_lane      <= 2'b00;
      r_we        <= 1'b0;
      r_narrow    <= 1'b0;
      r_wstrb     <= 4'b0000;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
    end else begin
      if (w_start) begin
        r_word_addr <= addr[31:2];
        r_lane      <= addr[1:0];
        r_we        <= MemWrite;
        r_narrow    <= !w_is_word;
        r_wstrb     <= w_wstrb;
        r_wdata     <= w_wdata;
      end
      // rdata is only non-zero in DONE; it drops back when DONE retires.
      if (w_complete) begin
        r_rdata <= w_rd_aligned;
      end else if (w_timeout || (r_state == ST_DONE)) begin
        r_rdata <= 32'd0;
      end
    end
  end

  assign mem_stall    = w_start | w_in_req;
  assign misalign_err = (r_state == ST_IDLE) && w_access && w_misalign;
  assign rdata        = r_rdata;
  assign bus_req      = w_in_req;
  assign bus_we       = r_we;
  assign bus_addr     = {r_word_addr, 2'b00};
  assign bus_wstrb    = r_wstrb;
  assign bus_wdata    = r_wdata;

endmodule

// File: tb/tb_data_mem_bus_interface.sv
// Scoreboard bench for data_mem_bus_interface: directed plan cases plus random load/store traffic.
// Define DMEM_TIMEOUT_EN to also exercise the timeout abort with TIMEOUT_CYCLES=4.
`timescale 1ns/1ps
module tb_data_mem_bus_interface;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  DataMemOutOp = 3'b001;
  logic [31:0] addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        misalign_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  always #5 clk = ~clk;

  data_mem_bus_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .DataMemOutOp(DataMemOutOp), .addr(addr), .write_data(write_data),
    .mem_stall(mem_stall), .rdata(rdata), .misalign_err(misalign_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit          mis;
    logic [31:0] baddr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cur_word = 32'd0;
  int          cur_waits = 0;
  bit          after_done = 0;
  logic [2:0]  ops[8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b000, 3'b110, 3'b111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event with no expectation pending at %0t", name, $time);
  endtask

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'b010, 3'b100: return 1;
      3'b011, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Reference model: expectations from byte-lane arithmetic, then drive the request.
  task automatic issue(input bit wr, input bit rd, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int waits,
                       input bit no_wait);
    exp_t e;
    int   sz;
    int   off;
    int   k;
    sz  = op_size(op);
    off = int'(a % 4);
    e   = '{default: '0};
    e.mis = (a % sz) != 0;
    if (e.mis) begin
      exp_q.push_back(e);
      MemWrite = wr; MemRead = rd; DataMemOutOp = op; addr = a; write_data = wd;
      repeat (after_done ? 2 : 1) begin @(posedge clk); #1; end
      MemRead = 0; MemWrite = 0;
      after_done = 0;
      return;
    end
    e.baddr = a - off;
    e.we    = wr;
    for (int b = 0; b < 4; b++) if (wr && b >= off && b < off + sz) e.strb[b] = 1'b1;
    if (wr) e.wdata = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                      (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    e.err   = waits >= TO;
    e.rdata = (wr || e.err) ? 32'd0 : ((sz == 4) ? word : word >> (8 * off));
    e.stall = e.err ? TO + 1 : waits + 2;
    cur_word  = word;
    cur_waits = waits;
    exp_q.push_back(e);
    MemWrite = wr; MemRead = rd; DataMemOutOp = op; addr = a; write_data = wd;
    if (no_wait) return;
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!mem_stall) break;
    end
    if (k == 400) begin
      n_vec++; n_err++;
      $display("FAIL access_wait: stall still %b expected 0 after %0d cycles", mem_stall, k);
    end
    after_done = 1;
  endtask

  // Bus responder: ready after cur_waits REQ cycles; random ready/data outside REQ.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n && bus_req) begin
      bus_ready = (wcnt == cur_waits);
      bus_rdata = bus_ready ? cur_word : $urandom;
      wcnt++;
    end else begin
      wcnt      = 0;
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
    end
  end

  // Monitor: pops the scoreboard on misalign pulses and on the DONE cycle.
  bit   prev_req = 0;
  int   stall_run = 0;
  exp_t m;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req  = 0;
      stall_run = 0;
    end else begin
      if (mem_stall) stall_run++;
      if (misalign_err) begin
        if (exp_q.size() == 0) note_fail("misalign_unexpected");
        else begin
          m = exp_q.pop_front();
          chk("misalign_kind", 32'(m.mis), 32'd1);
          chk("misalign_stall", 32'(mem_stall), 32'd0);
          chk("misalign_bus_req", 32'(bus_req), 32'd0);
          chk("misalign_rdata", rdata, 32'd0);
        end
      end
      if (bus_req) begin
        if (exp_q.size() == 0) note_fail("bus_req_unexpected");
        else begin
          m = exp_q[0];
          chk("req_kind", 32'(m.mis), 32'd0);
          chk("bus_addr", bus_addr, m.baddr);
          chk("bus_we", 32'(bus_we), 32'(m.we));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(m.strb));
          if (m.we) chk("bus_wdata", bus_wdata, m.wdata);
          chk("req_stall", 32'(mem_stall), 32'd1);
        end
      end
      if (!bus_req && prev_req) begin
        if (exp_q.size() == 0) note_fail("done_unexpected");
        else begin
          m = exp_q.pop_front();
          chk("done_rdata", rdata, m.rdata);
          chk("done_bus_err", 32'(bus_err), 32'(m.err));
          chk("done_stall", 32'(mem_stall), 32'd0);
          chk("stall_cycles", 32'(stall_run), 32'(m.stall));
        end
      end
      if (!mem_stall) stall_run = 0;
      prev_req = bus_req;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    bit          wr;
    bit          rd;
    int          sz;
    int          g;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 1, 3'b001, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    issue(0, 1, 3'b010, 32'h203, 32'h0, 32'h8011_2233, 3, 0);
    issue(1, 0, 3'b010, 32'h302, 32'h0000_00A5, 32'h0, 1, 0);
    issue(1, 0, 3'b011, 32'h302, 32'h0000_BEEF, 32'h0, 0, 0);
    issue(0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0);
    issue(1, 0, 3'b011, 32'h103, 32'h1234, 32'h0, 0, 0);
`ifdef DMEM_TIMEOUT_EN
    issue(0, 1, 3'b001, 32'h500, 32'h0, 32'hCAFE_F00D, 100, 0);
    issue(0, 1, 3'b001, 32'h504, 32'h0, 32'h1357_9BDF, TO - 1, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 7)];
      sz = op_size(op);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef DMEM_TIMEOUT_EN
      issue(wr, rd, op, a, $urandom, $urandom, $urandom_range(0, 6), 0);
`else
      issue(wr, rd, op, a, $urandom, $urandom, $urandom_range(0, 5), 0);
`endif
      g = $urandom_range(0, 2);
      if (g > 0) begin
        MemRead = 0; MemWrite = 0;
        repeat (g) begin @(posedge clk); #1; end
        after_done = 0;
      end
    end

    // Reset in the middle of a store's REQ phase.
    MemRead = 0; MemWrite = 0;
    repeat (2) begin @(posedge clk); #1; end
    after_done = 0;
    issue(1, 0, 3'b001, 32'h440, 32'h1234_5678, 32'h0, 50, 1);
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0; MemWrite = 0; MemRead = 0;
    #1;
    chk("midrst_stall", 32'(mem_stall), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_misalign", 32'(misalign_err), 32'd0);
    chk("midrst_bus_err", 32'(bus_err), 32'd0);
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_bus_we", 32'(bus_we), 32'd0);
    chk("midrst_bus_addr", bus_addr, 32'd0);
    chk("midrst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("midrst_bus_wdata", bus_wdata, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("postrst_bus_req", 32'(bus_req), 32'd0);
      chk("postrst_stall", 32'(mem_stall), 32'd0);
    end
    issue(0, 1, 3'b101, 32'h602, 32'h0, 32'hA1B2_C3D4, 2, 0);

    MemRead = 0; MemWrite = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
